kogge_stone_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface. It is the successor to the fixed 4-bit combinational prefix adder. Width and pipeline register spacing are configurable, and a per-operation subtract mode is added. The block serves as the wide-adder primitive for datapath blocks that need full throughput at high clock rates and tolerate backpressure.

---
 rtl/kogge_stone_adder_pipe_if.sv | 26 ++
 rtl/kogge_stone_adder_pipe.sv | 123 ++++++++++++
 tb/tb_kogge_stone_adder_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kogge_stone_adder_pipe_if.sv
// Stream bundle for the pipelined Kogge-Stone adder: operation in, result out.
interface kogge_stone_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/kogge_stone_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor; registers after every REG_EVERY prefix
// levels plus an input stage, with a valid bit per stage and a combinational stall chain.
module kogge_stone_adder_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1
) (
  input logic                    clk,
  input logic                    arst_n,
  kogge_stone_adder_pipe_if.slave bus
);
  localparam int L   = $clog2(WIDTH);
  localparam int NR  = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int LAT = 1 + NR;

  // Valid/ready: a transfer happens on a rising edge where valid && ready.
  // Stage s (0..NR, NR = output) advances when valid and the next stage is
  // empty or advancing; the output stage advances on out_ready.
  logic [LAT-1:0] v;
  logic [LAT-1:0] adv;
  logic [LAT-1:0] rdy;

  always_comb begin
    adv     = '0;
    rdy     = '0;
    adv[NR] = v[NR] & bus.out_ready;
    rdy[NR] = ~v[NR] | adv[NR];
    for (int s = NR - 1; s >= 0; s--) begin
      adv[s] = v[s] & rdy[s+1];
      rdy[s] = ~v[s] | adv[s];
    end
  end

  assign bus.in_ready = rdy[0];

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic             c0;

  // Carry-in is folded into bit 0 so the prefix tree only ever sees G/P.
  always_comb begin
    bx    = bus.Sub ? ~bus.B : bus.B;
    c0    = bus.Sub | bus.Cin;
    p0    = bus.A ^ bx;
    g0    = bus.A & bx;
    g0[0] = g0[0] | (p0[0] & c0);
  end

  logic [WIDTH-1:0] raw_q [NR];
  logic [WIDTH-1:0] p_q   [NR];
  logic [WIDTH-1:0] g_q   [NR];
  logic [NR-1:0]    cin_q;
  logic [WIDTH-1:0] nxt_p [NR];
  logic [WIDTH-1:0] nxt_g [NR];

  // Prefix levels between register s and s+1; descending i keeps reads on the previous level.
  always_comb begin
    for (int s = 0; s < NR; s++) begin
      nxt_p[s] = p_q[s];
      nxt_g[s] = g_q[s];
      for (int k = s * REG_EVERY + 1; k <= L && k <= (s + 1) * REG_EVERY; k++) begin
        for (int i = WIDTH - 1; i >= (1 << (k - 1)); i--) begin
          nxt_g[s][i] = nxt_g[s][i] | (nxt_p[s][i] & nxt_g[s][i - (1 << (k - 1))]);
          nxt_p[s][i] = nxt_p[s][i] & nxt_p[s][i - (1 << (k - 1))];
        end
      end
    end
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  assign carry = nxt_g[NR-1];
  assign sum   = raw_q[NR-1] ^ {carry[WIDTH-2:0], cin_q[NR-1]};

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v      <= '0;
      cin_q  <= '0;
      for (int s = 0; s < NR; s++) begin
        raw_q[s] <= '0;
        p_q[s]   <= '0;
        g_q[s]   <= '0;
      end
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (rdy[0]) v[0] <= bus.in_valid;
      if (rdy[0] && bus.in_valid) begin
        raw_q[0] <= p0;
        p_q[0]   <= p0;
        g_q[0]   <= g0;
        cin_q[0] <= c0;
      end
      for (int s = 1; s < NR; s++) begin
        if (rdy[s]) v[s] <= adv[s-1];
        if (adv[s-1]) begin
          raw_q[s] <= raw_q[s-1];
          p_q[s]   <= nxt_p[s-1];
          g_q[s]   <= nxt_g[s-1];
          cin_q[s] <= cin_q[s-1];
        end
      end
      if (rdy[NR]) v[NR] <= adv[NR-1];
      // Output data only loads on a real transfer, so it holds while idle or stalled.
      if (adv[NR-1]) begin
        s_q    <= sum;
        cout_q <= carry[WIDTH-1];
        ovf_q  <= carry[WIDTH-1] ^ carry[WIDTH-2];
      end
    end
  end

  assign bus.out_valid = v[NR];
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_kogge_stone_adder_pipe.sv
// Bench for three adder configurations: 8-bit/LAT 4, 16-bit/LAT 3, 5-bit/LAT 2.
module tb_kogge_stone_adder_pipe;
  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  kogge_stone_adder_pipe_if #(.WIDTH(8))  b8 ();
  kogge_stone_adder_pipe_if #(.WIDTH(16)) b16 ();
  kogge_stone_adder_pipe_if #(.WIDTH(5))  b5 ();

  kogge_stone_adder_pipe #(.WIDTH(8),  .REG_EVERY(1)) dut8  (.clk(clk), .arst_n(arst_n), .bus(b8));
  kogge_stone_adder_pipe #(.WIDTH(16), .REG_EVERY(2)) dut16 (.clk(clk), .arst_n(arst_n), .bus(b16));
  kogge_stone_adder_pipe #(.WIDTH(5),  .REG_EVERY(3)) dut5  (.clk(clk), .arst_n(arst_n), .bus(b5));

  int n_chk  = 0;
  int n_pass = 0;

  // Entries are {Ovf, Cout, S zero-extended to 16 bits}.
  logic [17:0] exp8_q[$];
  logic [17:0] exp16_q[$];
  logic [17:0] exp5_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] mask;
    logic [16:0] bx;
    logic [16:0] total;
    logic [15:0] s;
    logic        ovf;
    mask  = (17'd1 << w) - 17'd1;
    bx    = sub ? (~{1'b0, b} & mask) : {1'b0, b};
    total = {1'b0, a} + bx + {16'd0, (sub | cin)};
    s     = total[15:0] & mask[15:0];
    ovf   = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
    return {ovf, total[w], s};
  endfunction

  function automatic logic [17:0] res(input int u);
    case (u)
      0:       return {b8.Ovf, b8.Cout, 8'h00, b8.S};
      1:       return {b16.Ovf, b16.Cout, b16.S};
      default: return {b5.Ovf, b5.Cout, 11'h000, b5.S};
    endcase
  endfunction

  function automatic logic rdy(input int u);
    case (u)
      0:       return b8.in_ready;
      1:       return b16.in_ready;
      default: return b5.in_ready;
    endcase
  endfunction

  function automatic logic ovalid(input int u);
    case (u)
      0:       return b8.out_valid;
      1:       return b16.out_valid;
      default: return b5.out_valid;
    endcase
  endfunction

  function automatic int qsize(input int u);
    case (u)
      0:       return exp8_q.size();
      1:       return exp16_q.size();
      default: return exp5_q.size();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int u, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    case (u)
      0: begin b8.in_valid = v;  b8.A = a[7:0];  b8.B = b[7:0];  b8.Cin = cin;  b8.Sub = sub;  end
      1: begin b16.in_valid = v; b16.A = a;      b16.B = b;      b16.Cin = cin; b16.Sub = sub; end
      default: begin b5.in_valid = v; b5.A = a[4:0]; b5.B = b[4:0]; b5.Cin = cin; b5.Sub = sub; end
    endcase
  endtask

  task automatic idle(input int u);
    drive(u, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic send(input int u, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, output int stalls);
    stalls = 0;
    drive(u, 1'b1, a, b, cin, sub);
    @(negedge clk);
    while (!rdy(u) && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!rdy(u)) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int u);
    int n = 0;
    while ((qsize(u) != 0 || ovalid(u)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", qsize(u), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input int u, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic [15:0] exp_s, input logic exp_c, input logic exp_o,
                      input string tag);
    int st;
    int n = 0;
    send(u, a, b, cin, sub, st);
    idle(u);
    @(negedge clk);
    while (!ovalid(u) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check({tag, "_timeout"}, 32'd0, 32'd1);
    check(tag, res(u), {exp_o, exp_c, exp_s});
    @(posedge clk);
    #1;
  endtask

  task automatic lat_check(input int u, input int lat, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [15:0] exp_s,
                           input logic exp_c, input logic exp_o, input string tag);
    int st;
    wait_empty(u);
    send(u, a, b, cin, sub, st);
    idle(u);
    repeat (lat - 2) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_early"}, ovalid(u), 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, ovalid(u), 1);
    check({tag, "_res"}, res(u), {exp_o, exp_c, exp_s});
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  logic        stl8;
  logic [17:0] held8;

  always @(negedge clk) begin
    if (!arst_n) begin
      stl8 = 1'b0;
    end else begin
      check("d8_in_ready", b8.in_ready, !(exp8_q.size() == 4 && !b8.out_ready));
      if (stl8) check("d8_stall_hold", {b8.out_valid, res(0)}, {1'b1, held8});
      if (b8.out_valid && b8.out_ready) begin
        if (exp8_q.size() == 0) check("d8_unexpected", 32'd1, 32'd0);
        else check("d8_result", res(0), exp8_q.pop_front());
      end
      if (b8.in_valid && b8.in_ready)
        exp8_q.push_back(model(8, {8'h00, b8.A}, {8'h00, b8.B}, b8.Cin, b8.Sub));
      stl8  = b8.out_valid && !b8.out_ready;
      held8 = res(0);
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      if (b16.out_valid && b16.out_ready) begin
        if (exp16_q.size() == 0) check("d16_unexpected", 32'd1, 32'd0);
        else check("d16_result", res(1), exp16_q.pop_front());
      end
      if (b16.in_valid && b16.in_ready)
        exp16_q.push_back(model(16, b16.A, b16.B, b16.Cin, b16.Sub));
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      if (b5.out_valid && b5.out_ready) begin
        if (exp5_q.size() == 0) check("d5_unexpected", 32'd1, 32'd0);
        else check("d5_result", res(2), exp5_q.pop_front());
      end
      if (b5.in_valid && b5.in_ready)
        exp5_q.push_back(model(5, {11'h000, b5.A}, {11'h000, b5.B}, b5.Cin, b5.Sub));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int stalls;
    logic stale;

    arst_n = 1'b0;
    for (int u = 0; u < 3; u++) idle(u);
    b8.out_ready  = 1'b1;
    b16.out_ready = 1'b1;
    b5.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {b8.out_valid, b16.out_valid, b5.out_valid}, 3'b000);
    check("rst_res8", res(0), 0);
    check("rst_res16", res(1), 0);
    check("rst_res5", res(2), 0);
    arst_n = 1'b1;
    check("rst_in_ready", {rdy(0), rdy(1), rdy(2)}, 3'b111);

    lat_check(0, 4, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, "d8_lat");
    lat_check(1, 3, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "d16_lat");
    lat_check(2, 2, 16'h0F, 16'h01, 1'b0, 1'b0, 16'h10, 1'b0, 1'b1, "d5_lat");

    run1(0, 16'h05, 16'h07, 1'b0, 1'b1, 16'hFE, 1'b0, 1'b0, "d8_sub_borrow");
    run1(0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1, "d8_sub_ovf");
    run1(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, "d8_wrap");
    run1(0, 16'h80, 16'h80, 1'b0, 1'b0, 16'h00, 1'b1, 1'b1, "d8_neg_ovf");
    run1(0, 16'h10, 16'h03, 1'b1, 1'b1, 16'h0D, 1'b1, 1'b0, "d8_sub_cin_ignored");
    run1(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "d16_ovf");
    run1(1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "d16_sub");
    run1(2, 16'h1F, 16'h1F, 1'b1, 1'b0, 16'h1F, 1'b1, 1'b0, "d5_cin");
    run1(2, 16'h10, 16'h01, 1'b0, 1'b1, 16'h0F, 1'b1, 1'b1, "d5_sub_ovf");

    stalls = 0;
    for (int i = 0; i < 10000; i++) begin
      send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st);
      stalls += st;
    end
    idle(1);
    check("d16_b2b_stalls", stalls, 0);
    wait_empty(1);

    stalls = 0;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        for (int c = 0; c < 4; c++) begin
          send(2, 16'(a), 16'(b), 1'(c), 1'(c >> 1), st);
          stalls += st;
        end
    idle(2);
    check("d5_sweep_stalls", stalls, 0);
    wait_empty(2);

    fork
      begin
        int s2;
        for (int i = 0; i < 8; i++)
          send(0, 16'(i * 37 + 5), 16'(i * 91 + 3), 1'(i % 3 == 0), 1'(i % 2), s2);
        idle(0);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          b8.out_ready = 1'($urandom_range(0, 1));
        end
        b8.out_ready = 1'b1;
      end
    join
    wait_empty(0);

    // Three operations in flight, the oldest sitting at the output.
    send(0, 16'h21, 16'h43, 1'b0, 1'b0, st);
    send(0, 16'h11, 16'h22, 1'b1, 1'b0, st);
    send(0, 16'h55, 16'h0A, 1'b0, 1'b1, st);
    idle(0);
    @(posedge clk);
    #1;
    check("mid_pre_valid", ovalid(0), 1);
    arst_n = 1'b0;
    exp8_q.delete();
    #1;
    check("mid_rst_valid", ovalid(0), 0);
    check("mid_rst_res", res(0), 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ovalid(0)) stale = 1'b1;
    end
    check("mid_no_stale", stale, 0);
    lat_check(0, 4, 16'h3C, 16'h0F, 1'b1, 1'b0, 16'h4C, 1'b0, 1'b0, "d8_post_rst");

    wait_empty(0);
    wait_empty(1);
    wait_empty(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule
